signal_history: RTL and testbench

Parametrised multi-stage history buffer that generalises the single-register "previous value" capture into a DEPTH-deep delay line of WIDTH-bit samples. It supports enable-gated sampling, flush, fill tracking, a selectable read tap, and per-bit rise/fall detection between the two newest samples. It sits beside datapath logic that needs p1/p2/…/pN copies of a bus without hand-instantiating one register per stage.

---
 rtl/signal_history_if.sv | 32 +++
 rtl/signal_history.sv | 83 ++++++++
 tb/tb_signal_history.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/signal_history_if.sv
// Bus bundle for signal_history: sample inputs, tap select and all history/edge outputs.
// The slave modport is the history buffer; the master modport is the logic that drives and reads it.
interface signal_history_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int TSW = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] din;
    logic             en;
    logic             flush;
    logic [TSW-1:0]   tap_sel;
    logic [WIDTH-1:0] tap_out;
    logic             tap_valid;
    logic [WIDTH-1:0] p1_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;
    logic [CW-1:0]    fill_count;
    logic             full;

    modport master (
        output din, en, flush, tap_sel,
        input  tap_out, tap_valid, p1_out, rise, fall, changed, fill_count, full
    );

    modport slave (
        input  din, en, flush, tap_sel,
        output tap_out, tap_valid, p1_out, rise, fall, changed, fill_count, full
    );
endinterface

// File: rtl/signal_history.sv
// DEPTH-deep delay line of WIDTH-bit samples with enable, flush, fill tracking,
// a selectable read tap and per-bit rise/fall detection between the two newest samples.
module signal_history #(
    parameter int               WIDTH       = 16,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    signal_history_if.slave  bus
);
    localparam int TSW = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int MW  = (TSW > CW) ? TSW : CW;

    logic [WIDTH-1:0] stage_reg [DEPTH];
    logic [CW-1:0]    fill_reg;
    logic [CW-1:0]    fill_next;
    logic [WIDTH-1:0] tap_mux;
    logic             have_pair;

    // Newest stage: a sample taken on the flush edge survives the flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_reg[0] <= RESET_VALUE;
        end else if (bus.en) begin
            stage_reg[0] <= bus.din;
        end else if (bus.flush) begin
            stage_reg[0] <= RESET_VALUE;
        end
    end

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    stage_reg[gi] <= RESET_VALUE;
                end else if (bus.flush) begin
                    stage_reg[gi] <= RESET_VALUE;
                end else if (bus.en) begin
                    stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    always_comb begin
        fill_next = fill_reg;
        if (bus.flush) begin
            fill_next = bus.en ? CW'(1) : '0;
        end else if (bus.en && (fill_reg != CW'(DEPTH))) begin
            fill_next = fill_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_reg <= '0;
        end else begin
            fill_reg <= fill_next;
        end
    end

    // Compare-based mux so an out-of-range tap_sel never indexes past the array.
    always_comb begin
        tap_mux = RESET_VALUE;
        for (int i = 0; i < DEPTH; i++) begin
            if (MW'(bus.tap_sel) == MW'(i)) begin
                tap_mux = stage_reg[i];
            end
        end
    end

    assign have_pair      = (fill_reg >= CW'(2));
    assign bus.tap_out    = tap_mux;
    assign bus.tap_valid  = (MW'(bus.tap_sel) < MW'(fill_reg));
    assign bus.p1_out     = stage_reg[0];
    assign bus.rise       = have_pair ? (stage_reg[0] & ~stage_reg[1]) : '0;
    assign bus.fall       = have_pair ? (~stage_reg[0] & stage_reg[1]) : '0;
    assign bus.changed    = |(bus.rise | bus.fall);
    assign bus.fill_count = fill_reg;
    assign bus.full       = (fill_reg == CW'(DEPTH));
endmodule

// File: tb/tb_signal_history.sv
// Table-driven bench for signal_history (WIDTH=16, DEPTH=4, nonzero RESET_VALUE) with an
// expected-result queue, plus a hand-written asynchronous reset sequence.
module tb_signal_history;
    localparam int          WIDTH = 16;
    localparam int          DEPTH = 4;
    localparam logic [15:0] RV    = 16'hA5A5;

    typedef struct {
        logic        en;
        logic        flush;
        logic [15:0] din;
        logic [1:0]  tsel;
        logic [15:0] p1;
        logic [2:0]  fill;
        logic [15:0] tap;
        logic        tv;
        logic [15:0] rise;
        logic [15:0] fall;
        logic        ch;
        logic        full;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs [24];
    vec_t exp_q [$];

    signal_history_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    signal_history #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(RV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, input logic flush, input logic [15:0] din,
                                input logic [1:0] tsel, input logic [15:0] p1,
                                input logic [2:0] fill, input logic [15:0] tap, input logic tv,
                                input logic [15:0] rise, input logic [15:0] fall,
                                input logic ch, input logic full);
        vec_t v;
        v.en = en; v.flush = flush; v.din = din; v.tsel = tsel; v.p1 = p1; v.fill = fill;
        v.tap = tap; v.tv = tv; v.rise = rise; v.fall = fall; v.ch = ch; v.full = full;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, ".p1_out"},     32'(bus.p1_out),     32'(e.p1));
        chk({tag, ".fill_count"}, 32'(bus.fill_count), 32'(e.fill));
        chk({tag, ".tap_out"},    32'(bus.tap_out),    32'(e.tap));
        chk({tag, ".tap_valid"},  32'(bus.tap_valid),  32'(e.tv));
        chk({tag, ".rise"},       32'(bus.rise),       32'(e.rise));
        chk({tag, ".fall"},       32'(bus.fall),       32'(e.fall));
        chk({tag, ".changed"},    32'(bus.changed),    32'(e.ch));
        chk({tag, ".full"},       32'(bus.full),       32'(e.full));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        checks = 0;
        errors = 0;

        // Fill and saturate: din 1..6.
        vecs[0]  = mk(1, 0, 16'h0001, 0, 16'h0001, 1, 16'h0001, 1, 16'h0000, 16'h0000, 0, 0);
        vecs[1]  = mk(1, 0, 16'h0002, 1, 16'h0002, 2, 16'h0001, 1, 16'h0002, 16'h0001, 1, 0);
        vecs[2]  = mk(1, 0, 16'h0003, 2, 16'h0003, 3, 16'h0001, 1, 16'h0001, 16'h0000, 1, 0);
        vecs[3]  = mk(1, 0, 16'h0004, 3, 16'h0004, 4, 16'h0001, 1, 16'h0004, 16'h0003, 1, 1);
        vecs[4]  = mk(1, 0, 16'h0005, 3, 16'h0005, 4, 16'h0002, 1, 16'h0001, 16'h0000, 1, 1);
        vecs[5]  = mk(1, 0, 16'h0006, 3, 16'h0006, 4, 16'h0003, 1, 16'h0002, 16'h0001, 1, 1);
        // Flush collisions: flush+en keeps the new sample, flush alone empties.
        vecs[6]  = mk(1, 1, 16'h1234, 1, 16'h1234, 1, RV,       0, 16'h0000, 16'h0000, 0, 0);
        vecs[7]  = mk(0, 1, 16'hFFFF, 0, RV,       0, RV,       0, 16'h0000, 16'h0000, 0, 0);
        // Partial fill tap.
        vecs[8]  = mk(1, 0, 16'h00AA, 0, 16'h00AA, 1, 16'h00AA, 1, 16'h0000, 16'h0000, 0, 0);
        vecs[9]  = mk(1, 0, 16'h0055, 1, 16'h0055, 2, 16'h00AA, 1, 16'h0055, 16'h00AA, 1, 0);
        vecs[10] = mk(0, 0, 16'h1111, 2, 16'h0055, 2, RV,       0, 16'h0055, 16'h00AA, 1, 0);
        // Edge detect with idle hold.
        vecs[11] = mk(1, 0, 16'h00F0, 0, 16'h00F0, 3, 16'h00F0, 1, 16'h00A0, 16'h0005, 1, 0);
        vecs[12] = mk(1, 0, 16'h0F00, 1, 16'h0F00, 4, 16'h00F0, 1, 16'h0F00, 16'h00F0, 1, 1);
        vecs[13] = mk(0, 0, 16'hFFFF, 2, 16'h0F00, 4, 16'h0055, 1, 16'h0F00, 16'h00F0, 1, 1);
        vecs[14] = mk(0, 0, 16'h0000, 2, 16'h0F00, 4, 16'h0055, 1, 16'h0F00, 16'h00F0, 1, 1);
        vecs[15] = mk(0, 0, 16'h1234, 2, 16'h0F00, 4, 16'h0055, 1, 16'h0F00, 16'h00F0, 1, 1);
        vecs[16] = mk(1, 0, 16'h0F00, 3, 16'h0F00, 4, 16'h0055, 1, 16'h0000, 16'h0000, 0, 1);
        // Stall: only enabled samples enter history.
        vecs[17] = mk(0, 1, 16'h7777, 0, RV,       0, RV,       0, 16'h0000, 16'h0000, 0, 0);
        vecs[18] = mk(1, 0, 16'h0011, 0, 16'h0011, 1, 16'h0011, 1, 16'h0000, 16'h0000, 0, 0);
        vecs[19] = mk(0, 0, 16'h0022, 1, 16'h0011, 1, RV,       0, 16'h0000, 16'h0000, 0, 0);
        vecs[20] = mk(1, 0, 16'h0033, 1, 16'h0033, 2, 16'h0011, 1, 16'h0022, 16'h0000, 1, 0);
        vecs[21] = mk(0, 0, 16'h0044, 2, 16'h0033, 2, RV,       0, 16'h0022, 16'h0000, 1, 0);
        vecs[22] = mk(1, 0, 16'h0055, 2, 16'h0055, 3, 16'h0011, 1, 16'h0044, 16'h0022, 1, 0);
        vecs[23] = mk(0, 0, 16'h0066, 3, 16'h0055, 3, RV,       0, 16'h0044, 16'h0022, 1, 0);

        reset       = 1'b0;
        bus.din     = '0;
        bus.en      = 1'b0;
        bus.flush   = 1'b0;
        bus.tap_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        $display("reset: p1=%h fill=%0d", bus.p1_out, bus.fill_count);
        chk_all("reset", mk(0, 0, 0, 0, RV, 0, RV, 0, 0, 0, 0, 0));

        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            bus.en      = vecs[i].en;
            bus.flush   = vecs[i].flush;
            bus.din     = vecs[i].din;
            bus.tap_sel = vecs[i].tsel;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            $display("vec%0d: en=%0b flush=%0b din=%h tsel=%0d -> p1=%h fill=%0d tap=%h/%0b rise=%h fall=%h",
                     i, e.en, e.flush, e.din, e.tsel, bus.p1_out, bus.fill_count,
                     bus.tap_out, bus.tap_valid, bus.rise, bus.fall);
            chk_all($sformatf("vec%0d", i), e);
        end

        // Asynchronous reset mid-stream (fill_count=3): clears before the next edge.
        @(negedge clk);
        bus.en      = 1'b1;
        bus.flush   = 1'b0;
        bus.din     = 16'hBEEF;
        bus.tap_sel = 2'd1;
        #1;
        reset = 1'b0;
        #1;
        $display("async reset: p1=%h fill=%0d tap=%h/%0b", bus.p1_out, bus.fill_count,
                 bus.tap_out, bus.tap_valid);
        chk_all("async_reset", mk(0, 0, 0, 0, RV, 0, RV, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk_all("reset_held", mk(0, 0, 0, 0, RV, 0, RV, 0, 0, 0, 0, 0));

        // Deassert mid-cycle; the first update lands on the next rising edge.
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        $display("post reset: p1=%h fill=%0d", bus.p1_out, bus.fill_count);
        chk_all("post_reset", mk(0, 0, 0, 0, 16'hBEEF, 1, RV, 0, 0, 0, 0, 0));

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
